// File: rtl/sad_accumulator_16bit.sv
// Sum-of-absolute-differences stage: turns subtractor result/borrow pairs into magnitudes,
// accumulates LEN of them with saturation and hands the block total out on a valid/ready port.
module sad_accumulator_16bit #(
  parameter int LEN   = 16,
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      result,
  input  logic             borrow,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] sad,
  output logic             sat
);

  localparam int CNT_W = $clog2(LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [ACC_W-1:0] ACC_MAX  = '1;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_acc_q, sat_acc_d;
  logic [ACC_W-1:0] sad_q, sad_d;
  logic             sat_q, sat_d;
  logic             out_valid_q, out_valid_d;

  logic             accept;
  logic [16:0]      mag;
  logic [ACC_W:0]   sum_wide;
  logic             overflow;
  logic [ACC_W-1:0] acc_sum;

  // A borrowed difference is result = A-B+2^16, so |A-B| = 2^16 - result (result=0 gives 2^16).
  always_comb begin
    mag = {1'b0, result};
    if (borrow) begin
      mag = 17'h10000 - {1'b0, result};
    end
  end

  always_comb begin
    sum_wide = {1'b0, acc_q} + {{(ACC_W - 16){1'b0}}, mag};
    overflow = sum_wide[ACC_W];
    acc_sum  = overflow ? ACC_MAX : sum_wide[ACC_W-1:0];
  end

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_acc_q   <= 1'b0;
      sad_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sat_acc_q   <= sat_acc_d;
      sad_q       <= sad_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Flush beats an accept in the same cycle; the last accept of a block publishes and restarts.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sat_acc_d   = sat_acc_q;
    sad_d       = sad_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ACCUM: begin
        if (flush) begin
          acc_d     = '0;
          cnt_d     = '0;
          sat_acc_d = 1'b0;
        end else if (accept) begin
          if (cnt_q == CNT_LAST) begin
            sad_d       = acc_sum;
            sat_d       = sat_acc_q | overflow;
            out_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            sat_acc_d   = 1'b0;
            state_d     = HOLD;
          end else begin
            acc_d     = acc_sum;
            cnt_d     = cnt_q + CNT_ONE;
            sat_acc_d = sat_acc_q | overflow;
          end
        end
      end
      HOLD: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ACCUM) && !rst;
    out_valid = out_valid_q;
    sad       = sad_q;
    sat       = sat_q;
  end

endmodule

// File: tb/tb_sad_accumulator_16bit.sv
// Directed bench for sad_accumulator_16bit: a LEN=4/ACC_W=17 instance for the block scenarios
// and a LEN=1 instance sharing the same inputs for the one-sample-per-block case.
module tb_sad_accumulator_16bit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] result;
  logic        borrow;
  logic        flush;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [16:0] sad;
  logic        sat;

  logic        in_ready_1;
  logic        out_valid_1;
  logic [23:0] sad_1;
  logic        sat_1;

  int total;
  int bad;

  sad_accumulator_16bit #(.LEN(4), .ACC_W(17)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .result(result), .borrow(borrow), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .sad(sad), .sat(sat)
  );

  sad_accumulator_16bit #(.LEN(1), .ACC_W(24)) u_dut_len1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_1),
    .result(result), .borrow(borrow), .flush(flush),
    .out_valid(out_valid_1), .out_ready(out_ready), .sad(sad_1), .sat(sat_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] r, input logic b);
    in_valid = v;
    result   = r;
    borrow   = b;
    step();
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    in_valid  = 1'b1;
    result    = 16'd7;
    borrow    = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;

    // Reset with a sample presented
    #1;
    checkOutput("rst_in_ready_0", 32'(in_ready), 32'd0);
    step();
    checkOutput("rst_in_ready_1", 32'(in_ready), 32'd0);
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_sad", 32'(sad), 32'd0);
    checkOutput("rst_sat", 32'(sat), 32'd0);
    checkOutput("rst_in_ready_after", 32'(in_ready), 32'd1);

    // Magnitude mix: 10 + 10 + 0 + 1 = 21
    applyStimulus(1'b1, 16'd10, 1'b0);
    applyStimulus(1'b1, 16'd65526, 1'b1);
    applyStimulus(1'b1, 16'd0, 1'b0);
    checkOutput("mix_no_early_valid", 32'(out_valid), 32'd0);
    applyStimulus(1'b1, 16'd65535, 1'b1);
    in_valid = 1'b0;
    checkOutput("mix_out_valid", 32'(out_valid), 32'd1);
    checkOutput("mix_sad", 32'(sad), 32'd21);
    checkOutput("mix_sat", 32'(sat), 32'd0);
    checkOutput("mix_hold_in_ready", 32'(in_ready), 32'd0);
    step();
    checkOutput("mix_valid_one_cycle", 32'(out_valid), 32'd0);
    checkOutput("mix_in_ready_back", 32'(in_ready), 32'd1);

    // Backpressure: 1+2+3+4 = 10 held while a stray sample waits
    out_ready = 1'b0;
    applyStimulus(1'b1, 16'd1, 1'b0);
    applyStimulus(1'b1, 16'd2, 1'b0);
    applyStimulus(1'b1, 16'd3, 1'b0);
    applyStimulus(1'b1, 16'd4, 1'b0);
    result = 16'd500;
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_sad", 32'(sad), 32'd10);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checkOutput("bp_release_valid", 32'(out_valid), 32'd0);
    checkOutput("bp_release_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'd7, 1'b0);
    in_valid = 1'b0;
    checkOutput("bp_nothing_leaked", 32'(sad), 32'd28);
    step();

    // Saturation: 4 x 65536 clips to 2^17-1
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'd0, 1'b1);
    in_valid = 1'b0;
    checkOutput("sat_sad", 32'(sad), 32'd131071);
    checkOutput("sat_flag", 32'(sat), 32'd1);
    step();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'd5, 1'b0);
    in_valid = 1'b0;
    checkOutput("sat_clear_sad", 32'(sad), 32'd20);
    checkOutput("sat_clear_flag", 32'(sat), 32'd0);
    step();

    // Flush mid-block drops the partial sum and the sample presented with it
    applyStimulus(1'b1, 16'd100, 1'b0);
    applyStimulus(1'b1, 16'd200, 1'b0);
    flush = 1'b1;
    applyStimulus(1'b1, 16'd999, 1'b0);
    flush = 1'b0;
    checkOutput("flush_no_valid", 32'(out_valid), 32'd0);
    applyStimulus(1'b1, 16'd1, 1'b0);
    applyStimulus(1'b1, 16'd1, 1'b0);
    applyStimulus(1'b1, 16'd1, 1'b0);
    out_ready = 1'b0;
    applyStimulus(1'b1, 16'd1, 1'b0);
    in_valid = 1'b0;
    checkOutput("flush_sad", 32'(sad), 32'd4);
    checkOutput("flush_out_valid", 32'(out_valid), 32'd1);

    // Flush in HOLD is ignored
    flush = 1'b1;
    step();
    flush = 1'b0;
    checkOutput("hold_flush_valid", 32'(out_valid), 32'd1);
    checkOutput("hold_flush_sad", 32'(sad), 32'd4);

    // Reset in HOLD discards the block
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checkOutput("hold_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("hold_rst_sad", 32'(sad), 32'd0);
    checkOutput("hold_rst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'd2, 1'b0);
    in_valid = 1'b0;
    checkOutput("post_rst_sad", 32'(sad), 32'd8);
    step();
    step();

    // LEN=1: each accepted sample is a block; (300,borrow) -> 65236
    checkOutput("len1_idle_ready", 32'(in_ready_1), 32'd1);
    applyStimulus(1'b1, 16'd300, 1'b1);
    in_valid = 1'b0;
    checkOutput("len1_out_valid", 32'(out_valid_1), 32'd1);
    checkOutput("len1_sad", 32'(sad_1), 32'd65236);
    checkOutput("len1_sat", 32'(sat_1), 32'd0);
    step();
    checkOutput("len1_drop_valid", 32'(out_valid_1), 32'd0);
    applyStimulus(1'b1, 16'd42, 1'b0);
    in_valid = 1'b0;
    checkOutput("len1_second_sad", 32'(sad_1), 32'd42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
